// File: rtl/cpu_pkg.sv
// Constants shared by the ALU and the multi-cycle multiply/divide sequencer.
// Holds the opcode values, the sequencer state encoding and the divide-by-zero result.
package cpu_pkg;

    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_MOD = 4'b0100;

    localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// Single iteration of the sequencer datapath. For MUL it does one shift-add step; for DIV/MOD it does
// one restoring-division step. hi/lo hold {accumulator high, multiplier} or {remainder, quotient}.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_mul,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        hi_next = hi;
        lo_next = lo;
        if (is_mul) begin
            // The 2*WIDTH accumulator {sum, lo} shifts right by one; the multiplier bits drain out of lo.
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_next = diff[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_next = {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo_next = {lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/MOD unit beside the ALU in EX. It does one bit per cycle, then a sign fix-up.
// Its results and flags match the single-cycle ALU, including the divide-by-zero convention.
module muldiv_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             div_by_zero
);

    // Handshake: a request is taken only when start is high in IDLE with a supported alu_op and no
    // flush. Operands are copied on that edge. busy covers CALC/FIX. done pulses for one cycle with
    // result and flags valid. Once a flush has been seen, no done is raised for that request.

    seq_state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             mul_q, mod_q, neg_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH-1:0] pend_result, held_result;
    logic             pend_z, pend_n, pend_dbz;
    logic             held_z, held_n, held_dbz;
    logic             accept, div_zero;
    logic [WIDTH-1:0] fix_val, fix_res;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign accept   = (state == ST_IDLE) && start && !flush && is_muldiv_op(alu_op);
    assign div_zero = (alu_op != ALU_MUL) && (operand2 == '0);

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_mul  (mul_q),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opnd_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = div_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == '0) next_state = ST_FIX;
            ST_FIX:  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    always_comb begin
        fix_val = mod_q ? hi_q : lo_q;
        fix_res = neg_q ? -fix_val : fix_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            busy_q      <= 1'b0;
            mul_q       <= 1'b0;
            mod_q       <= 1'b0;
            neg_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            pend_result <= '0;
            pend_z      <= 1'b0;
            pend_n      <= 1'b0;
            pend_dbz    <= 1'b0;
            held_result <= '0;
            held_z      <= 1'b0;
            held_n      <= 1'b0;
            held_dbz    <= 1'b0;
        end else begin
            busy_q <= (next_state == ST_CALC) || (next_state == ST_FIX);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mul_q  <= (alu_op == ALU_MUL);
                        mod_q  <= (alu_op == ALU_MOD);
                        neg_q  <= (alu_op == ALU_DIV) ? (operand1[WIDTH-1] ^ operand2[WIDTH-1])
                                : (alu_op == ALU_MOD) ? operand1[WIDTH-1] : 1'b0;
                        cnt    <= CNT_W'(WIDTH - 1);
                        hi_q   <= '0;
                        lo_q   <= (alu_op == ALU_MUL) ? operand2 : mag(operand1);
                        opnd_q <= (alu_op == ALU_MUL) ? operand1 : mag(operand2);
                        if (div_zero) begin
                            pend_result <= WIDTH'(DIV_ZERO_RESULT);
                            pend_z      <= 1'b0;
                            pend_n      <= 1'b0;
                            pend_dbz    <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    hi_q <= hi_next;
                    lo_q <= lo_next;
                    cnt  <= cnt - 1'b1;
                end
                ST_FIX: begin
                    pend_result <= fix_res;
                    pend_z      <= (fix_res == '0);
                    pend_n      <= fix_res[WIDTH-1];
                    pend_dbz    <= 1'b0;
                end
                ST_DONE: begin
                    // The result only becomes architectural if the done pulse is actually delivered.
                    if (!flush) begin
                        held_result <= pend_result;
                        held_z      <= pend_z;
                        held_n      <= pend_n;
                        held_dbz    <= pend_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = (state == ST_DONE) && !flush && !rst;
    assign result        = done ? pend_result : held_result;
    assign zero_flag     = done ? pend_z      : held_z;
    assign negative_flag = done ? pend_n      : held_n;
    assign div_by_zero   = done ? pend_dbz    : held_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, MUL/DIV/MOD results, flags, divide-by-zero,
// flush, reset mid-operation and ignored start requests.
module tb_muldiv_sequencer;
    import cpu_pkg::*;

    logic        clk, rst, start, flush;
    logic [3:0]  alu_op;
    logic [31:0] operand1, operand2;
    logic        busy, done, zero_flag, negative_flag, div_by_zero;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .alu_op        (alu_op),
        .operand1      (operand1),
        .operand2      (operand2),
        .flush         (flush),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .div_by_zero   (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start pulse at cycle 0, then follow the operation until done (or a 60-cycle budget expires).
    // Returns in the done cycle, #1 after its rising edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int busy_cnt, output logic [31:0] r,
                          output logic z, output logic n, output logic dz);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; alu_op = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0; alu_op = 4'($urandom_range(0, 15));
        operand1 = $urandom; operand2 = $urandom;
        cyc = 1; done_cyc = -1; busy_cnt = 0;
        r = '0; z = 1'b0; n = 1'b0; dz = 1'b0;
        while (cyc <= 60 && done_cyc < 0) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc; r = result; z = zero_flag; n = negative_flag; dz = div_by_zero;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0; alu_op = ALU_MUL; operand1 = 32'd3; operand2 = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if ({zero_flag, negative_flag, div_by_zero} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got z%b n%b dz%b want 000", zero_flag, negative_flag, div_by_zero);
        end
    endtask

    task automatic test_mul();
        logic [31:0] va [5] = '{32'd7, 32'd12345, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        logic [31:0] vb [5] = '{32'hFFFFFFFD, 32'd6789, 32'hFFFFFFFF, 32'hDEADBEEF, 32'd2};
        logic [31:0] ve [5] = '{32'hFFFFFFEB, 32'h04FED79D, 32'h00000001, 32'h0, 32'h0};
        int dc, bc;
        logic [31:0] r;
        logic z, n, dz;
        for (int i = 0; i < 5; i++) begin
            run_op(ALU_MUL, va[i], vb[i], dc, bc, r, z, n, dz);
            checks++; if (dc !== 34) begin failures++; $display("FAIL mul_latency[%0d]: got %0d want 34", i, dc); end
            checks++; if (bc !== 33) begin failures++; $display("FAIL mul_busy_cycles[%0d]: got %0d want 33", i, bc); end
            checks++; if (r !== ve[i]) begin failures++; $display("FAIL mul_result[%0d]: got %h want %h", i, r, ve[i]); end
            checks++; if ({z, n, dz} !== {ve[i] == 32'd0, ve[i][31], 1'b0}) begin
                failures++; $display("FAIL mul_flags[%0d]: got z%b n%b dz%b", i, z, n, dz);
            end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || result !== ve[i]) begin
                failures++; $display("FAIL mul_hold[%0d]: got done=%b result=%h want 0/%h", i, done, result, ve[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]  vo [8] = '{ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD};
        logic [31:0] va [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'd3, 32'hFFFFFFFA};
        logic [31:0] vb [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd5, 32'd3};
        logic [31:0] ve [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'd0, 32'd0};
        int dc, bc;
        logic [31:0] r;
        logic z, n, dz;
        for (int i = 0; i < 8; i++) begin
            run_op(vo[i], va[i], vb[i], dc, bc, r, z, n, dz);
            checks++; if (dc !== 34 || bc !== 33) begin
                failures++; $display("FAIL div_timing[%0d]: got done@%0d busy=%0d want 34/33", i, dc, bc);
            end
            checks++; if (r !== ve[i]) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, r, ve[i]); end
            checks++; if ({z, n, dz} !== {ve[i] == 32'd0, ve[i][31], 1'b0}) begin
                failures++; $display("FAIL div_flags[%0d]: got z%b n%b dz%b", i, z, n, dz);
            end
        end
    endtask

    task automatic test_overflow();
        int dc, bc;
        logic [31:0] r;
        logic z, n, dz;
        run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, dc, bc, r, z, n, dz);
        checks++; if (r !== 32'h80000000 || n !== 1'b1 || z !== 1'b0) begin
            failures++; $display("FAIL ovf_div: got %h z%b n%b want 80000000 z0 n1", r, z, n);
        end
        run_op(ALU_MOD, 32'h80000000, 32'hFFFFFFFF, dc, bc, r, z, n, dz);
        checks++; if (r !== 32'h0 || z !== 1'b1 || n !== 1'b0) begin
            failures++; $display("FAIL ovf_mod: got %h z%b n%b want 0 z1 n0", r, z, n);
        end
    endtask

    task automatic test_div_zero();
        int dc, bc;
        logic [31:0] r;
        logic z, n, dz;
        run_op(ALU_DIV, 32'd5, 32'd0, dc, bc, r, z, n, dz);
        checks++; if (dc !== 1 || bc !== 0) begin
            failures++; $display("FAIL dz_timing: got done@%0d busy=%0d want 1/0", dc, bc);
        end
        checks++; if (r !== 32'hFFFFFFFF || {z, n, dz} !== 3'b001) begin
            failures++; $display("FAIL dz_div: got %h z%b n%b dz%b want ffffffff 001", r, z, n, dz);
        end
        run_op(ALU_MOD, 32'hFFFFFFF9, 32'd0, dc, bc, r, z, n, dz);
        checks++; if (dc !== 1 || r !== 32'hFFFFFFFF || {z, n, dz} !== 3'b001) begin
            failures++; $display("FAIL dz_mod: got done@%0d %h z%b n%b dz%b", dc, r, z, n, dz);
        end
        @(posedge clk); #1;
        checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_hold: got %b want 1", div_by_zero); end
        run_op(ALU_DIV, 32'd100, 32'd7, dc, bc, r, z, n, dz);
        checks++; if (dz !== 1'b0 || r !== 32'd14) begin
            failures++; $display("FAIL dz_clear: got dz%b %h want dz0 0000000e", dz, r);
        end
    endtask

    task automatic test_flush();
        int dc, bc, seen;
        logic [31:0] r;
        logic z, n, dz;
        run_op(ALU_DIV, 32'd100, 32'd7, dc, bc, r, z, n, dz);
        @(posedge clk); #1;
        start = 1'b1; alu_op = ALU_MUL; operand1 = 32'd3; operand2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; seen = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (done) seen++;
            if (cyc == 10) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_c10: got %b want 1", busy); end
            end
            flush = (cyc == 10);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_c11: got %b want 0", busy); end
        checks++; if (seen !== 0 || done !== 1'b0) begin failures++; $display("FAIL flush_no_done: saw %0d done", seen); end
        checks++; if (result !== 32'd14 || zero_flag !== 1'b0) begin
            failures++; $display("FAIL flush_result_kept: got %h z%b want 0000000e z0", result, zero_flag);
        end
        run_op(ALU_MUL, 32'd3, 32'd4, dc, bc, r, z, n, dz);
        checks++; if (dc !== 34 || r !== 32'd12) begin
            failures++; $display("FAIL flush_restart: got done@%0d %h want 34 0000000c", dc, r);
        end
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; alu_op = ALU_MUL; operand1 = 32'd5; operand2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (busy || done) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0 || result !== 32'd12) begin
            failures++; $display("FAIL flush_beats_start: active %0d cycles result %h want 0 0000000c", seen, result);
        end
    endtask

    task automatic test_ignored_start();
        int dc;
        @(posedge clk); #1;
        start = 1'b1; alu_op = ALU_DIV; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; dc = -1;
        for (int cyc = 1; cyc <= 60 && dc < 0; cyc++) begin
            if (done) begin
                dc = cyc;
                start = 1'b0;
                checks++; if (result !== 32'd14) begin failures++; $display("FAIL ignored_result: got %h want 0000000e", result); end
            end else begin
                start = (cyc == 2 || cyc == 15 || cyc == 33);
                alu_op = (cyc == 15) ? 4'b0101 : ALU_MUL;
                operand1 = $urandom; operand2 = $urandom;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        checks++; if (dc !== 34) begin failures++; $display("FAIL ignored_latency: got %0d want 34", dc); end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        logic [31:0] r;
        logic z, n, dz;
        run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, dc, bc, r, z, n, dz);
        checks++; if (r !== 32'hFFFFFFFD || n !== 1'b1) begin
            failures++; $display("FAIL b2b_div: got %h n%b want fffffffd n1", r, n);
        end
        start = 1'b1; alu_op = ALU_MUL; operand1 = 32'd2; operand2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFFFFFD) begin
            failures++; $display("FAIL b2b_start_in_done: got busy%b done%b %h want 0 0 fffffffd", busy, done, result);
        end
        run_op(ALU_MOD, 32'hFFFFFFF9, 32'd2, dc, bc, r, z, n, dz);
        checks++; if (dc !== 34 || r !== 32'hFFFFFFFF || n !== 1'b1) begin
            failures++; $display("FAIL b2b_mod: got done@%0d %h n%b want 34 ffffffff n1", dc, r, n);
        end
        run_op(ALU_MUL, 32'd2, 32'd3, dc, bc, r, z, n, dz);
        checks++; if (dc !== 34 || r !== 32'd6) begin
            failures++; $display("FAIL b2b_earliest: got done@%0d %h want 34 00000006", dc, r);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(posedge clk); #1;
        start = 1'b1; alu_op = ALU_DIV; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) seen++;
            start = (cyc == 3 || cyc == 7 || cyc == 9);
            alu_op = (cyc == 9) ? 4'b0101 : ALU_MUL;
            operand1 = $urandom; operand2 = $urandom;
            rst = (cyc == 20);
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || seen !== 0) begin
            failures++; $display("FAIL rstmid_ctrl: got busy%b done%b seen%0d want 0 0 0", busy, done, seen);
        end
        checks++; if (result !== 32'h0 || {zero_flag, negative_flag, div_by_zero} !== 3'b000) begin
            failures++; $display("FAIL rstmid_outputs: got %h z%b n%b dz%b want all 0", result, zero_flag, negative_flag, div_by_zero);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen); end
        start = 1'b1; alu_op = 4'b0101; operand1 = 32'd9; operand2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0 || result !== 32'h0) begin
            failures++; $display("FAIL unsupported_op: got %0d active cycles result %h want 0 0", seen, result);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_overflow();
        test_div_zero();
        test_flush();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
